// File: rtl/ahb_mailbox_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ahb_mailbox_pkg : shared AHB encodings, data-phase states, mailbox defaults
// Rev 1.0
// ---------------------------------------------------------------------------
package ahb_mailbox_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    DP_IDLE = 2'd0,
    DP_WR   = 2'd1,
    DP_RD   = 2'd2
  } dphase_e;

  localparam logic [31:0] MBOX_ADDR_DEFAULT = 32'hD058_0000;
  localparam logic [7:0]  PASS_CODE_DEFAULT = 8'hFF;
  localparam logic [7:0]  FAIL_CODE_DEFAULT = 8'h01;

endpackage
`default_nettype wire

// File: rtl/mbox_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mbox_fifo : DEPTH x 8 synchronous FIFO with wrap-bit pointers
// Rev 1.0
// ---------------------------------------------------------------------------
module mbox_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [7:0]               din_i,
  input  logic                     pop_i,
  output logic [7:0]               dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Head is forced to zero when empty so the sink never sees stale storage.
  assign dout_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule
`default_nettype wire

// File: rtl/ahb_mailbox.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ahb_mailbox : AHB-Lite mailbox target -> paced character stream + pass/fail
// Rev 1.0
// ---------------------------------------------------------------------------
module ahb_mailbox
  import ahb_mailbox_pkg::*;
#(
  parameter logic [31:0] MBOX_ADDR  = MBOX_ADDR_DEFAULT,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  PASS_CODE  = PASS_CODE_DEFAULT,
  parameter logic [7:0]  FAIL_CODE  = FAIL_CODE_DEFAULT
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [63:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [63:0] HRDATA,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        test_pass,
  output logic        test_fail
);

  localparam int CW = $clog2(FIFO_DEPTH);

  dphase_e      state_q, state_d;
  logic [2:0]   lane_q, lane_d;
  logic         pass_q, pass_d;
  logic         fail_q, fail_d;

  logic         accept, addr_hit;
  logic [7:0]   wr_byte;
  logic         is_code;
  logic         push, pop;
  logic         fifo_full, fifo_empty;
  logic [CW:0]  fifo_count;
  logic [3:0]   count_sat;
  logic [7:0]   status;
  logic         unused_ok;

  assign unused_ok = ^HSIZE;

  assign accept   = HSEL && HREADY &&
                    (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign addr_hit = (HADDR[31:3] == MBOX_ADDR[31:3]);

  assign wr_byte  = HWDATA[{lane_q, 3'b000} +: 8];
  assign is_code  = (wr_byte == PASS_CODE) || (wr_byte == FAIL_CODE);

  // Only a character destined for a full FIFO stalls; codes never do.
  assign HREADYOUT = !((state_q == DP_WR) && fifo_full && !is_code);
  assign HRESP     = 1'b0;

  assign push = (state_q == DP_WR) && !is_code && HREADYOUT;
  assign pop  = char_valid && char_ready;

  assign count_sat = (32'(fifo_count) > 15) ? 4'd15 : 4'(fifo_count);
  assign status    = {fail_q, pass_q, fifo_full, fifo_empty, count_sat};

  assign char_valid = !fifo_empty;
  assign test_pass  = pass_q;
  assign test_fail  = fail_q;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    if (HREADYOUT) begin
      state_d = DP_IDLE;
      if (accept && addr_hit) begin
        state_d = HWRITE ? DP_WR : DP_RD;
        lane_d  = HADDR[2:0];
      end
    end
    if (state_q == DP_WR) begin
      if (wr_byte == PASS_CODE) pass_d = 1'b1;
      if (wr_byte == FAIL_CODE) fail_d = 1'b1;
    end
  end

  always_comb begin
    HRDATA = '0;
    if (state_q == DP_RD) HRDATA[{lane_q, 3'b000} +: 8] = status;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= DP_IDLE;
      lane_q  <= 3'd0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  mbox_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (HCLK),
    .rst_ni  (HRESETn),
    .push_i  (push),
    .din_i   (wr_byte),
    .pop_i   (pop),
    .dout_o  (char_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule
`default_nettype wire
